seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns (active-low, bit6 = a .. bit0 = g),
// BCD nibble type and the scan decoder FSM states.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] Seg0 = 7'b0000001;
  localparam logic [6:0] Seg1 = 7'b1001111;
  localparam logic [6:0] Seg2 = 7'b0010010;
  localparam logic [6:0] Seg3 = 7'b0000110;
  localparam logic [6:0] Seg4 = 7'b1001100;
  localparam logic [6:0] Seg5 = 7'b0100100;
  localparam logic [6:0] Seg6 = 7'b0100000;
  localparam logic [6:0] Seg7 = 7'b0001111;
  localparam logic [6:0] Seg8 = 7'b0000000;
  localparam logic [6:0] Seg9 = 7'b0000100;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StHold   = 2'd1,
    StCommit = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; pat_ok is low for any pattern outside
// the ten digit glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output bcd_t       bcd,
  output logic       pat_ok
);

  always_comb begin
    bcd    = '0;
    pat_ok = 1'b1;
    case (seg_n)
      Seg0:    bcd = 4'd0;
      Seg1:    bcd = 4'd1;
      Seg2:    bcd = 4'd2;
      Seg3:    bcd = 4'd3;
      Seg4:    bcd = 4'd4;
      Seg5:    bcd = 4'd5;
      Seg6:    bcd = 4'd6;
      Seg7:    bcd = 4'd7;
      Seg8:    bcd = 4'd8;
      Seg9:    bcd = 4'd9;
      default: pat_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a BCD frame by snooping a multiplexed 7-segment display bus.
// Define SEG7_SCAN_DP_EN to also recover the per-digit decimal points (dp_n / dp).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
`ifdef SEG7_SCAN_DP_EN
  input  logic              dp_n,
  output logic [NDIG-1:0]   dp,
`endif
  output logic [4*NDIG-1:0] digits,
  output logic              valid,
  output logic              err
);

  localparam int unsigned IdxW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [3:0]  CntMax = 4'(STABLE_CNT);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [IdxW-1:0]     prev_idx_q;
  logic [6:0]          prev_seg_q;
  logic [4*NDIG-1:0]   shadow_q;
  logic [4*NDIG-1:0]   digits_q;
  logic [NDIG-1:0]     seen_q;
  logic                valid_q;
  logic                err_q;

  // Sample classification
  logic [3:0]          hot_cnt;
  logic [IdxW-1:0]     idx;
  logic                is_blank;
  logic                is_multi;
  logic                same_smp;
  logic [3:0]          cnt_nxt;
  bcd_t                bcd;
  logic                pat_ok;
  logic [4*NDIG-1:0]   shadow_upd;
  logic [NDIG-1:0]     seen_upd;

  seg7_pattern_decode u_decode (
    .seg_n  (seg_n),
    .bcd    (bcd),
    .pat_ok (pat_ok)
  );

  always_comb begin
    hot_cnt = 4'd0;
    idx     = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_n[i]) begin
        hot_cnt = hot_cnt + 4'd1;
        idx     = IdxW'(i);
      end
    end
  end

  assign is_blank = (hot_cnt == 4'd0);
  assign is_multi = (hot_cnt > 4'd1);

`ifdef SEG7_SCAN_DP_EN
  logic                prev_dp_q;
  logic [NDIG-1:0]     dp_shadow_q;
  logic [NDIG-1:0]     dp_q;
  logic [NDIG-1:0]     dp_upd;

  assign same_smp = (idx == prev_idx_q) && (seg_n == prev_seg_q) && (dp_n == prev_dp_q);
  assign dp       = dp_q;
`else
  assign same_smp = (idx == prev_idx_q) && (seg_n == prev_seg_q);
`endif

  always_comb begin
    if (!same_smp) begin
      cnt_nxt = 4'd1;
    end else if (cnt_q >= CntMax) begin
      cnt_nxt = CntMax;
    end else begin
      cnt_nxt = cnt_q + 4'd1;
    end
  end

  // Shadow/seen contents as they would be if the current sample were accepted.
  always_comb begin
    shadow_upd = shadow_q;
    seen_upd   = seen_q;
`ifdef SEG7_SCAN_DP_EN
    dp_upd     = dp_shadow_q;
`endif
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IdxW'(i)) begin
        shadow_upd[4*i +: 4] = bcd;
        seen_upd[i]          = 1'b1;
`ifdef SEG7_SCAN_DP_EN
        dp_upd[i]            = ~dp_n;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSearch;
      cnt_q       <= '0;
      prev_idx_q  <= '0;
      prev_seg_q  <= '0;
      shadow_q    <= '0;
      digits_q    <= '0;
      seen_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      prev_dp_q   <= 1'b0;
      dp_shadow_q <= '0;
      dp_q        <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        StCommit: begin
          // digits/valid were loaded on the entering edge; only housekeeping here.
          seen_q  <= '0;
          state_q <= StSearch;
        end
        default: begin
          if (sample_en) begin
            if (is_multi) begin
              err_q   <= 1'b1;
              seen_q  <= '0;
              cnt_q   <= '0;
              state_q <= StSearch;
            end else if (is_blank) begin
              cnt_q   <= '0;
              state_q <= StSearch;
            end else begin
              prev_idx_q <= idx;
              prev_seg_q <= seg_n;
`ifdef SEG7_SCAN_DP_EN
              prev_dp_q  <= dp_n;
`endif
              if (state_q == StHold) begin
                if (!same_smp) begin
                  cnt_q   <= 4'd1;
                  state_q <= StSearch;
                end
              end else begin
                cnt_q <= cnt_nxt;
                if (cnt_nxt == CntMax) begin
                  if (pat_ok) begin
                    shadow_q <= shadow_upd;
                    seen_q   <= seen_upd;
`ifdef SEG7_SCAN_DP_EN
                    dp_shadow_q <= dp_upd;
`endif
                    if (&seen_upd) begin
                      state_q  <= StCommit;
                      digits_q <= shadow_upd;
                      valid_q  <= 1'b1;
`ifdef SEG7_SCAN_DP_EN
                      dp_q     <= dp_upd;
`endif
                    end else begin
                      state_q <= StHold;
                    end
                  end else begin
                    err_q   <= 1'b1;
                    state_q <= StHold;
                  end
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign digits = digits_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule
